abft_chk_acc_gen: RTL
=====================

Name: abft_chk_acc_gen

Overview:
Parametrised next-generation checksum accumulator for the ABFT systolic-array datapath.
- Sums NUM_CH checksum channels (generalises the fixed w/x/y/z set) over frames of ARRAY_SIZE beats. Each of the ARRAY_SIZE columns arrives with systolic skew.
- Emits one registered per-column total per cycle.
- New relative to the previous generation: runtime frame abort, per-column overflow flag, and selectable saturate/wrap arithmetic.
- Sits between the array's checksum taps and the ABFT comparator.

Parameters:
ARRAY_SIZE, 4, columns per channel and beats per frame (>=2)
NUM_CH, 4, number of checksum channels (>=1)
A_BITS, 20, signed input width
Z_BITS, 28, signed accumulator/output width; Z_BITS >= A_BITS
SAT_EN, 0, 1 = saturate on overflow, 0 = two's-complement wrap
ADDR_W, $clog2(ARRAY_SIZE), counter/column-index width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset
valid_in  in  1  beat valid for column 0; column c is implied valid c cycles later
in_data  in  NUM_CH x ARRAY_SIZE x A_BITS  signed samples, [ch][col], column c skewed by c cycles
valid_out  out  1  acc_out/col_idx/ovf hold a finished column total
col_idx  out  ADDR_W  column of current output
acc_out  out  NUM_CH x Z_BITS  signed column totals
ovf  out  NUM_CH  overflow occurred in this column's sum
abort_out  out  1  one-cycle pulse: frame discarded

Behaviour:
Interface and reset:
- Single clock clk. rst is synchronous and active-high.
- On rst: all outputs are 0, the beat counter is 0, all skew pipelines are cleared, and all accumulators are 0.
- Any partial frame in flight at reset is discarded and produces no output. Skewed column data arriving after reset is ignored.

Framing:
- Beat counter cnt in 0..ARRAY_SIZE-1 increments on valid_in.
- A frame starts when valid_in=1 with cnt=0 (cycle t0). It ends on the beat where cnt=ARRAY_SIZE-1, after which cnt wraps to 0.
- valid_in=0 with cnt=0 means idle, with no effect.
- valid_in=0 with cnt!=0 aborts the frame:
  - cnt returns to 0.
  - abort_out pulses 1 on the next cycle.
  - The per-column abort travels down the same skew chain (column c sees it c cycles later).
  - No valid_out is produced for the aborted frame.
  - A new frame may start on the cycle immediately after the abort cycle.

Column pipeline:
- Column c uses valid, start-of-frame and end-of-frame flags delayed by c cycles. in_data[*][c] is sampled only when its delayed valid is 1; otherwise it is don't-care.
- Start-of-frame: the accumulator loads the sign-extended sample.
- Other valid beats: the accumulator adds the sample.
- Overflow: per-column, per-channel flag, set on any overflow within the frame, reloaded at start-of-frame.
  - SAT_EN=1: the result clamps to +2^(Z_BITS-1)-1 or -2^(Z_BITS-1).
  - SAT_EN=0: the result wraps modulo 2^Z_BITS.

Output:
- The final sum of column c is registered to acc_out/ovf at cycle t0+ARRAY_SIZE+c, with valid_out=1 and col_idx=c.
- valid_out is high for ARRAY_SIZE consecutive cycles, with col_idx stepping 0..ARRAY_SIZE-1.
- Latency is ARRAY_SIZE cycles from a column's first beat to its output.
- Back-to-back frames (no idle gap) produce contiguous valid_out with no overlap. A column reloads on the cycle its previous total is presented, with no loss.
- When valid_out=0, acc_out, ovf and col_idx hold 0.

Decomposition:
- Package abft_acc_pkg holds:
  - sat_add function (signed add, saturate/wrap, overflow flag)
  - typedefs for sample and acc vectors parameterised via the package
  - constant helpers for ADDR_W
- Sub-module abft_col_acc: one channel-column accumulator (load/add/sat/ovf), instantiated NUM_CH x ARRAY_SIZE.
- Skew chains and the output mux live in the top level.

Test Plan:
1. ARRAY_SIZE=4, NUM_CH=4, all samples 1 in one frame at t0 -> valid_out cycles t0+4..t0+7, col_idx 0,1,2,3, every acc_out=4, ovf=0.
2. Column c correctly skewed with value c+1; all off-skew slots driven 0x5A5A5 -> acc_out per col = 4,8,12,16 (garbage ignored).
3. Frame A (all 1) then frame B (all -2) back-to-back -> 8 contiguous valid_out cycles: 4,4,4,4 then -8,-8,-8,-8 (0xFFFFFF8).
4. valid_in drops at beat 2 -> abort_out=1 next cycle, no valid_out for that frame; an immediate following all-3 frame gives 12 on all columns.
5. A_BITS=20, Z_BITS=21, all samples 0x7FFFF -> SAT_EN=1: acc_out=0x0FFFFF, ovf=1; SAT_EN=0: acc_out=0x1FFFFC (-4), ovf=1.
6. rst asserted at beat 3 of a frame -> all outputs 0 next cycle, no valid_out from the killed frame; a subsequent all-1 frame gives 4s.

Source files
------------

// File: rtl/abft_acc_pkg.sv
// ----------------------------------------------------------------------------
// abft_acc_pkg
// Shared definitions for the ABFT checksum accumulator.
//   - default geometry constants and the sample/accumulator vector typedefs
//     built from them
//   - sat_add: signed add with overflow detection and optional clamping,
//     evaluated in a wide working width so a single function serves every
//     accumulator width up to 62 bits
//   - calcAddrW: column-index width helper (never narrower than one bit)
// ----------------------------------------------------------------------------
package abft_acc_pkg;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_A_BITS     = 20;
    localparam int DEF_Z_BITS     = 28;

    // Working width for sat_add; must exceed the largest accumulator width
    // by at least two bits so the true sum never wraps inside the function.
    localparam int CALC_W = 64;

    typedef logic signed [DEF_A_BITS-1:0]             sample_t;
    typedef logic signed [DEF_Z_BITS-1:0]             acc_t;
    typedef sample_t [DEF_NUM_CH-1:0][DEF_ARRAY_SIZE-1:0] sampleVec_t;
    typedef acc_t [DEF_NUM_CH-1:0]                    accVec_t;

    typedef struct packed {
        logic signed [CALC_W-1:0] sum;
        logic                     ovf;
    } addRes_t;

    // Width of a counter that indexes n columns.
    function automatic int calcAddrW(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Adds two sign-extended operands and reports whether the true result
    // leaves the zBits signed range. With satEn the result is clamped to the
    // nearest bound; otherwise the caller keeps the low zBits, which is the
    // two's-complement wrapped value.
    function automatic addRes_t sat_add(input logic signed [CALC_W-1:0] a,
                                        input logic signed [CALC_W-1:0] b,
                                        input int                       zBits,
                                        input logic                     satEn);
        logic signed [CALC_W-1:0] maxV;
        logic signed [CALC_W-1:0] minV;
        logic signed [CALC_W-1:0] sum;
        addRes_t                  res;
        maxV    = (64'sd1 <<< (zBits - 1)) - 64'sd1;
        minV    = -maxV - 64'sd1;
        sum     = a + b;
        res.sum = sum;
        res.ovf = (sum > maxV) || (sum < minV);
        if (res.ovf && satEn) begin
            res.sum = (sum > maxV) ? maxV : minV;
        end
        return res;
    endfunction

endpackage

// File: rtl/abft_col_acc.sv
// ----------------------------------------------------------------------------
// abft_col_acc
// One channel/column accumulator: loads the sign-extended sample at start of
// frame, adds on every other valid beat, and keeps a sticky overflow flag for
// the frame. The next-state values are exported so the top level can
// register a column's final total on the same edge that completes it.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        delayed beat valid for this column
//   i_sof          delayed start-of-frame for this column
//   i_abort        delayed frame abort for this column
//   i_sample       signed input sample (A_BITS)
//   o_accNext      accumulator value after the current beat (Z_BITS)
//   o_ovfNext      overflow flag after the current beat
// ----------------------------------------------------------------------------
module abft_col_acc import abft_acc_pkg::*; #(
    parameter int A_BITS = 20,
    parameter int Z_BITS = 28,
    parameter int SAT_EN = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic                     i_abort,
    input  logic signed [A_BITS-1:0] i_sample,
    output logic signed [Z_BITS-1:0] o_accNext,
    output logic                     o_ovfNext
);

    logic signed [Z_BITS-1:0] r_acc;
    logic                     r_ovf;
    addRes_t                  w_res;

    // Next-state of the accumulator. A start-of-frame beat reloads both the
    // sum and the overflow flag, so a previous frame's total can be presented
    // on the very cycle this column begins its next frame. An abort simply
    // clears the partial sum it was building.
    always_comb begin
        w_res     = sat_add(CALC_W'(r_acc), CALC_W'(i_sample), Z_BITS, SAT_EN != 0);
        o_accNext = r_acc;
        o_ovfNext = r_ovf;
        if (i_valid) begin
            if (i_sof) begin
                o_accNext = Z_BITS'(i_sample);
                o_ovfNext = 1'b0;
            end else begin
                o_accNext = w_res.sum[Z_BITS-1:0];
                o_ovfNext = r_ovf | w_res.ovf;
            end
        end else if (i_abort) begin
            o_accNext = '0;
            o_ovfNext = 1'b0;
        end
    end

    // Accumulator state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= o_accNext;
            r_ovf <= o_ovfNext;
        end
    end

endmodule

// File: rtl/abft_chk_acc_gen.sv
// ----------------------------------------------------------------------------
// abft_chk_acc_gen
// Checksum accumulator between the systolic array taps and the ABFT
// comparator. Sums NUM_CH channels over frames of ARRAY_SIZE beats where
// column c arrives c cycles after column 0, and presents one finished column
// total per cycle.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid_in     beat valid for column 0 (column c implied c cycles later)
//   i_in_data      [ch][col] signed samples, column c skewed by c cycles
//   o_valid_out    output holds a finished column total
//   o_col_idx      column of the current output
//   o_acc_out      [ch] signed column totals
//   o_ovf          [ch] overflow seen during this column's sum
//   o_abort_out    one-cycle pulse: the frame in progress was discarded
// ----------------------------------------------------------------------------
module abft_chk_acc_gen import abft_acc_pkg::*; #(
    parameter int ARRAY_SIZE = 4,
    parameter int NUM_CH     = 4,
    parameter int A_BITS     = 20,
    parameter int Z_BITS     = 28,
    parameter int SAT_EN     = 0,
    parameter int ADDR_W     = calcAddrW(ARRAY_SIZE)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_valid_in,
    input  logic [NUM_CH-1:0][ARRAY_SIZE-1:0][A_BITS-1:0] i_in_data,
    output logic                                        o_valid_out,
    output logic [ADDR_W-1:0]                           o_col_idx,
    output logic [NUM_CH-1:0][Z_BITS-1:0]               o_acc_out,
    output logic [NUM_CH-1:0]                           o_ovf,
    output logic                                        o_abort_out
);

    logic [ADDR_W-1:0]             r_beatCnt;
    logic                          w_lastBeat;

    logic [ARRAY_SIZE-1:0]         w_valid;
    logic [ARRAY_SIZE-1:0]         w_sof;
    logic [ARRAY_SIZE-1:0]         w_eof;
    logic [ARRAY_SIZE-1:0]         w_abort;
    logic [ARRAY_SIZE-2:0]         r_validSr;
    logic [ARRAY_SIZE-2:0]         r_sofSr;
    logic [ARRAY_SIZE-2:0]         r_eofSr;
    logic [ARRAY_SIZE-2:0]         r_abortSr;

    logic signed [Z_BITS-1:0]      w_accNext [ARRAY_SIZE][NUM_CH];
    logic [NUM_CH-1:0]             w_ovfNext [ARRAY_SIZE];

    logic                          w_hit;
    logic [ADDR_W-1:0]             w_selCol;
    logic [NUM_CH-1:0][Z_BITS-1:0] w_selAcc;
    logic [NUM_CH-1:0]             w_selOvf;

    logic                          r_validOut;
    logic [ADDR_W-1:0]             r_colIdx;
    logic [NUM_CH-1:0][Z_BITS-1:0] r_accOut;
    logic [NUM_CH-1:0]             r_ovfOut;
    logic                          r_abortOut;

    assign w_lastBeat = (r_beatCnt == ADDR_W'(ARRAY_SIZE - 1));

    // Column 0 control flags come straight from the input and the beat
    // counter; column c sees the same flags c cycles later through the
    // shift registers. Dropping valid mid-frame is the abort condition.
    always_comb begin
        w_valid[0] = i_valid_in;
        w_sof[0]   = i_valid_in && (r_beatCnt == '0);
        w_eof[0]   = i_valid_in && w_lastBeat;
        w_abort[0] = !i_valid_in && (r_beatCnt != '0);
        w_valid[ARRAY_SIZE-1:1] = r_validSr;
        w_sof[ARRAY_SIZE-1:1]   = r_sofSr;
        w_eof[ARRAY_SIZE-1:1]   = r_eofSr;
        w_abort[ARRAY_SIZE-1:1] = r_abortSr;
    end

    // Beat counter plus the skew chains. Each chain stage i feeds column
    // i+1, so the whole chain is one parallel load of the lower columns.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beatCnt <= '0;
            r_validSr <= '0;
            r_sofSr   <= '0;
            r_eofSr   <= '0;
            r_abortSr <= '0;
        end else begin
            if (i_valid_in) begin
                r_beatCnt <= w_lastBeat ? '0 : r_beatCnt + 1'b1;
            end else begin
                r_beatCnt <= '0;
            end
            r_validSr <= w_valid[ARRAY_SIZE-2:0];
            r_sofSr   <= w_sof[ARRAY_SIZE-2:0];
            r_eofSr   <= w_eof[ARRAY_SIZE-2:0];
            r_abortSr <= w_abort[ARRAY_SIZE-2:0];
        end
    end

    // One accumulator per channel and column; the raw input already carries
    // the systolic skew, so samples are not delayed here.
    for (genvar gCol = 0; gCol < ARRAY_SIZE; gCol++) begin : gColumn
        for (genvar gCh = 0; gCh < NUM_CH; gCh++) begin : gChannel
            abft_col_acc #(
                .A_BITS (A_BITS),
                .Z_BITS (Z_BITS),
                .SAT_EN (SAT_EN)
            ) u_colAcc (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_valid   (w_valid[gCol]),
                .i_sof     (w_sof[gCol]),
                .i_abort   (w_abort[gCol]),
                .i_sample  ($signed(i_in_data[gCh][gCol])),
                .o_accNext (w_accNext[gCol][gCh]),
                .o_ovfNext (w_ovfNext[gCol][gCh])
            );
        end
    end

    // Pick the column finishing its frame this cycle. Successive frames are
    // at least ARRAY_SIZE cycles apart, so at most one column ends at a time.
    always_comb begin
        w_hit    = 1'b0;
        w_selCol = '0;
        w_selAcc = '0;
        w_selOvf = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            if (w_eof[c]) begin
                w_hit    = 1'b1;
                w_selCol = ADDR_W'(c);
                w_selOvf = w_ovfNext[c];
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    w_selAcc[ch] = w_accNext[c][ch];
                end
            end
        end
    end

    // Output registers: a finished total is captured on the edge that adds
    // its last beat, and everything reads zero when nothing is finishing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_validOut <= 1'b0;
            r_colIdx   <= '0;
            r_accOut   <= '0;
            r_ovfOut   <= '0;
            r_abortOut <= 1'b0;
        end else begin
            r_validOut <= w_hit;
            r_colIdx   <= w_selCol;
            r_accOut   <= w_selAcc;
            r_ovfOut   <= w_selOvf;
            r_abortOut <= w_abort[0];
        end
    end

    assign o_valid_out = r_validOut;
    assign o_col_idx   = r_colIdx;
    assign o_acc_out   = r_accOut;
    assign o_ovf       = r_ovfOut;
    assign o_abort_out = r_abortOut;

endmodule
